// File: rtl/dekatron_chain.sv
// Multi-digit dekatron/octotron ring-counter chain with one-hot digits,
// up/down stepping, parallel load and one-digit-per-clock carry ripple.
module dekatron_chain #(
  parameter int DIGITS = 3,
  parameter int RADIX  = 10
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     En,
  input  logic                     Step,
  input  logic                     Reverse,
  input  logic                     Set,
  input  logic [DIGITS*RADIX-1:0]  In,
  output logic [DIGITS*RADIX-1:0]  Out,
  output logic                     Busy,
  output logic                     Zero,
  output logic                     Overflow
);

  localparam int W  = DIGITS * RADIX;
  localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic logic [W-1:0] home_vec();
    logic [W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < DIGITS; i++) v[i*RADIX] = 1'b1;
    return v;
  endfunction

  function automatic logic is_onehot(input logic [RADIX-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned b = 0; b < RADIX; b++) n += 32'(v[b]);
    return n == 1;
  endfunction

  localparam logic [W-1:0] HOME = home_vec();

  typedef enum logic {IDLE, RIPPLE} state_t;

  state_t          state;
  logic [W-1:0]    pos;
  logic [W-1:0]    load_val;
  logic [KW-1:0]   k;
  logic            dir;

  int unsigned     base;
  logic [RADIX-1:0] cur;
  logic [RADIX-1:0] nxt;
  logic            cur_dir;
  logic            wrap;

  // One rotator serves both the Step on digit 0 (IDLE) and the ripple digit k.
  always_comb begin
    base = 0;
    if (state == RIPPLE) base = 32'(k) * 32'(RADIX);
    cur     = pos[base +: RADIX];
    cur_dir = (state == RIPPLE) ? dir : Reverse;
    wrap    = cur_dir ? cur[0] : cur[RADIX-1];
    nxt     = cur_dir ? {cur[0], cur[RADIX-1:1]} : {cur[RADIX-2:0], cur[RADIX-1]};
  end

  // Malformed load slices fall back to position 0 so Out stays one-hot.
  always_comb begin
    load_val = '0;
    for (int unsigned i = 0; i < DIGITS; i++)
      load_val[i*RADIX +: RADIX] = is_onehot(In[i*RADIX +: RADIX]) ?
                                   In[i*RADIX +: RADIX] : RADIX'(1);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pos      <= HOME;
      state    <= IDLE;
      k        <= '0;
      dir      <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      Overflow <= 1'b0;
      if (Set) begin
        pos   <= load_val;
        state <= IDLE;
        k     <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (Step && En) begin
              dir              <= Reverse;
              pos[RADIX-1:0]   <= nxt;
              if (wrap) begin
                if (DIGITS > 1) begin
                  k     <= KW'(1);
                  state <= RIPPLE;
                end else begin
                  Overflow <= 1'b1;
                end
              end
            end
          end
          RIPPLE: begin
            pos[base +: RADIX] <= nxt;
            if (!wrap) begin
              state <= IDLE;
            end else if (32'(k) == 32'(DIGITS - 1)) begin
              Overflow <= 1'b1;
              state    <= IDLE;
            end else begin
              k <= k + KW'(1);
            end
          end
        endcase
      end
    end
  end

  assign Out  = pos;
  assign Busy = (state == RIPPLE);
  assign Zero = (pos == HOME) && (state != RIPPLE);

endmodule
